// File: rtl/knn_stream_engine_if.sv
// -----------------------------------------------------------------------------
// knn_stream_engine_if
// Training-point stream between a producer and knn_stream_engine.
//
// Handshake: a beat transfers on every rising clock edge where trn_valid and
// trn_ready are both high. The master holds trn_point/trn_label/trn_last
// stable while trn_valid is high and trn_ready is low; trn_ready never
// depends combinationally on trn_valid.
//
// Signals:
//   trn_valid  master -> slave  beat valid
//   trn_ready  slave  -> master engine accepts beat
//   trn_point  master -> slave  N_DIM*DATA_W training coordinates, dim 0 in LSBs
//   trn_label  master -> slave  LABEL_W training label
//   trn_last   master -> slave  final beat of the run
// -----------------------------------------------------------------------------
interface knn_stream_engine_if #(
  parameter int DATA_W  = 16,
  parameter int N_DIM   = 2,
  parameter int LABEL_W = 8
);
  logic                      trn_valid;
  logic                      trn_ready;
  logic [N_DIM*DATA_W-1:0]   trn_point;
  logic [LABEL_W-1:0]        trn_label;
  logic                      trn_last;

  modport master (
    output trn_valid, trn_point, trn_label, trn_last,
    input  trn_ready
  );

  modport slave (
    input  trn_valid, trn_point, trn_label, trn_last,
    output trn_ready
  );
endinterface

// File: rtl/knn_stream_engine.sv
// -----------------------------------------------------------------------------
// knn_stream_engine
// k-nearest-neighbour engine: holds one test point, streams labelled training
// points, computes squared Euclidean distance in two pipeline stages and keeps
// a stable-sorted list of the K nearest neighbours (slot 0 nearest).
//
// Optional feature macro: KNN_VOTE_EN
//   defined   : K-cycle VOTE state computes a majority label (ties -> nearest)
//   undefined : no VOTE state, vote_label tied to 0
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   clear         synchronous abort: IDLE next cycle, list emptied, pipe flushed
//   test_load     capture test_point and start a run (IDLE/DONE only)
//   test_point    N_DIM*DATA_W signed test coordinates, dim 0 in LSBs
//   trn           training stream (slave modport)
//   busy, done    state is RUN/DRAIN/VOTE; result stable
//   count         number of valid slots
//   nb_dist       K*DIST_W slot distances (invalid slots all-ones)
//   nb_label      K*LABEL_W slot labels (invalid slots 0)
//   vote_label    majority label
//   dbg_state     current FSM state encoding
// -----------------------------------------------------------------------------
module knn_stream_engine #(
  parameter int DATA_W  = 16,
  parameter int N_DIM   = 2,
  parameter int K       = 4,
  parameter int LABEL_W = 8,
  parameter int DIST_W  = 2*DATA_W+2+$clog2(N_DIM)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          test_load,
  input  logic [N_DIM*DATA_W-1:0]       test_point,
  knn_stream_engine_if.slave            trn,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(K+1)-1:0]        count,
  output logic [K*DIST_W-1:0]           nb_dist,
  output logic [K*LABEL_W-1:0]          nb_label,
  output logic [LABEL_W-1:0]            vote_label,
  output logic [2:0]                    dbg_state
);
  localparam int SQ_W  = 2*DATA_W+2;
  localparam int CNT_W = $clog2(K+1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_VOTE, S_DONE} state_t;

  state_t                   r_state;
  logic                     r_trn_ready, r_busy, r_done;
  logic [DATA_W-1:0]        r_test    [N_DIM];
  logic signed [DATA_W:0]   w_diff    [N_DIM];
  logic signed [SQ_W-1:0]   w_diff_x  [N_DIM];
  logic [SQ_W-1:0]          w_sq      [N_DIM];
  logic [SQ_W-1:0]          r_sq      [N_DIM];
  logic                     r_s1_v, r_s2_v;
  logic [LABEL_W-1:0]       r_s1_label, r_s2_label;
  logic [DIST_W-1:0]        w_sum, r_s2_dist;
  logic [DIST_W-1:0]        r_dist    [K];
  logic [LABEL_W-1:0]       r_label   [K];
  logic [DIST_W-1:0]        w_nxt_dist  [K];
  logic [LABEL_W-1:0]       w_nxt_label [K];
  logic [K-1:0]             w_le;
  logic [CNT_W-1:0]         r_count;
  logic                     w_accept, w_start;

  assign w_accept = trn.trn_valid && r_trn_ready && !clear;
  assign w_start  = test_load && (r_state == S_IDLE || r_state == S_DONE);

  // Stage-1 combinational: per-dimension signed difference and square.
  always_comb begin
    for (int i = 0; i < N_DIM; i++) begin
      w_diff[i]   = $signed({trn.trn_point[i*DATA_W+DATA_W-1], trn.trn_point[i*DATA_W +: DATA_W]})
                  - $signed({r_test[i][DATA_W-1], r_test[i]});
      w_diff_x[i] = SQ_W'(w_diff[i]);
      w_sq[i]     = w_diff_x[i] * w_diff_x[i];
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_DIM; i++) w_sum = w_sum + DIST_W'(r_sq[i]);
  end

  // w_le is a prefix mask of slots at or nearer than the candidate; the first
  // zero bit marks the insertion point, and '<=' keeps earlier ties nearer.
  always_comb begin
    for (int j = 0; j < K; j++)
      w_le[j] = (CNT_W'(j) < r_count) && (r_dist[j] <= r_s2_dist);
    w_nxt_dist[0]  = w_le[0] ? r_dist[0]  : r_s2_dist;
    w_nxt_label[0] = w_le[0] ? r_label[0] : r_s2_label;
    for (int j = 1; j < K; j++) begin
      w_nxt_dist[j]  = w_le[j] ? r_dist[j]  : (w_le[j-1] ? r_s2_dist  : r_dist[j-1]);
      w_nxt_label[j] = w_le[j] ? r_label[j] : (w_le[j-1] ? r_s2_label : r_label[j-1]);
    end
  end

`ifdef KNN_VOTE_EN
  logic [CNT_W-1:0]   r_vidx;
  logic [CNT_W-1:0]   w_votes, r_best_votes;
  logic [LABEL_W-1:0] w_cur_label, r_best_label, r_vote_label;
  logic               w_take;
`endif

  // Control FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_trn_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef KNN_VOTE_EN
      r_vidx      <= '0;
`endif
    end else if (clear) begin
      r_state     <= S_IDLE;
      r_trn_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (test_load) begin
          r_state     <= S_RUN;
          r_trn_ready <= 1'b1;
          r_busy      <= 1'b1;
          r_done      <= 1'b0;
        end
        S_RUN: if (w_accept && trn.trn_last) begin
          r_state     <= S_DRAIN;
          r_trn_ready <= 1'b0;
        end
        // Stage 1 empty means the last beat sits in stage 2 and lands in the
        // list on this edge, so the result is complete next cycle.
        S_DRAIN: if (!r_s1_v) begin
`ifdef KNN_VOTE_EN
          r_state <= S_VOTE;
          r_vidx  <= '0;
`else
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
`endif
        end
`ifdef KNN_VOTE_EN
        S_VOTE: begin
          if (r_vidx == CNT_W'(K-1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_vidx <= r_vidx + CNT_W'(1);
          end
        end
`endif
        default: begin
          r_state     <= S_IDLE;
          r_trn_ready <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: pipeline stages and neighbour list.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_v     <= 1'b0;
      r_s2_v     <= 1'b0;
      r_s1_label <= '0;
      r_s2_label <= '0;
      r_s2_dist  <= '0;
      r_count    <= '0;
      for (int i = 0; i < N_DIM; i++) begin
        r_test[i] <= '0;
        r_sq[i]   <= '0;
      end
      for (int j = 0; j < K; j++) begin
        r_dist[j]  <= '1;
        r_label[j] <= '0;
      end
    end else begin
      r_s1_v <= w_accept;
      r_s2_v <= r_s1_v && !clear;
      if (w_accept) begin
        for (int i = 0; i < N_DIM; i++) r_sq[i] <= w_sq[i];
        r_s1_label <= trn.trn_label;
      end
      if (r_s1_v) begin
        r_s2_dist  <= w_sum;
        r_s2_label <= r_s1_label;
      end
      if (clear || w_start) begin
        r_count <= '0;
        for (int j = 0; j < K; j++) begin
          r_dist[j]  <= '1;
          r_label[j] <= '0;
        end
        if (!clear)
          for (int i = 0; i < N_DIM; i++) r_test[i] <= test_point[i*DATA_W +: DATA_W];
      end else if (r_s2_v) begin
        for (int j = 0; j < K; j++) begin
          r_dist[j]  <= w_nxt_dist[j];
          r_label[j] <= w_nxt_label[j];
        end
        if (r_count != CNT_W'(K)) r_count <= r_count + CNT_W'(1);
      end
    end
  end

`ifdef KNN_VOTE_EN
  // Vote cycle i scores slot i; the list is frozen while voting.
  always_comb begin
    w_cur_label = '0;
    for (int j = 0; j < K; j++)
      if (CNT_W'(j) == r_vidx) w_cur_label = r_label[j];
    w_votes = '0;
    for (int j = 0; j < K; j++)
      if (CNT_W'(j) < r_count && r_label[j] == w_cur_label) w_votes = w_votes + CNT_W'(1);
    // Slot 0 seeds the running best; later slots need strictly more votes.
    w_take = (r_vidx < r_count) && (r_vidx == '0 || w_votes > r_best_votes);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_best_votes <= '0;
      r_best_label <= '0;
      r_vote_label <= '0;
    end else if (!clear && r_state == S_VOTE) begin
      if (w_take) begin
        r_best_votes <= w_votes;
        r_best_label <= w_cur_label;
      end
      if (r_vidx == CNT_W'(K-1))
        r_vote_label <= w_take ? w_cur_label : r_best_label;
    end
  end

  assign vote_label = r_vote_label;
`else
  assign vote_label = '0;
`endif

  always_comb begin
    for (int j = 0; j < K; j++) begin
      nb_dist[j*DIST_W +: DIST_W]    = r_dist[j];
      nb_label[j*LABEL_W +: LABEL_W] = r_label[j];
    end
  end

  assign trn.trn_ready = r_trn_ready;
  assign busy          = r_busy;
  assign done          = r_done;
  assign count         = r_count;
  assign dbg_state     = r_state;
endmodule

// File: doc/knn_stream_engine.md
Name: knn_stream_engine

Overview:
- Parametrised k-nearest-neighbour engine; successor to the fixed single-dimension KNN core.
- Holds one test point of N_DIM signed coordinates and accepts a valid/ready stream of labelled training points.
- Computes squared Euclidean distance in a 2-stage pipeline and keeps a sorted list of the K nearest neighbours.
- Sits behind the KNN software register file; the CPU reads the list and an optional majority-vote label.

Parameters:
- DATA_W, 16, coordinate width, signed two's complement
- N_DIM, 2, dimensions per point, 1..8
- K, 4, number of neighbours kept, 1..16
- LABEL_W, 8, label width
- DIST_W, 2*DATA_W+2+$clog2(N_DIM), derived distance width; not to be overridden

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- clear  in  1  synchronous abort: return to IDLE and empty the list
- test_load  in  1  load test_point and start a run
- test_point  in  N_DIM*DATA_W  test coordinates; dim 0 in the LSBs
- trn_valid  in  1  training beat valid
- trn_ready  out  1  engine accepts beat
- trn_point  in  N_DIM*DATA_W  training coordinates
- trn_label  in  LABEL_W  training label
- trn_last  in  1  final training beat of the run
- busy  out  1  state is RUN, DRAIN or VOTE
- done  out  1  level; result is stable
- count  out  $clog2(K+1)  number of valid slots
- nb_dist  out  K*DIST_W  slot i distance; slot 0 is nearest
- nb_label  out  K*LABEL_W  slot i label
- vote_label  out  LABEL_W  majority label (feature only)

Behaviour:
- Reset (rst low, takes effect immediately): state IDLE; pipeline valids 0; count 0; every nb_dist all-ones; every nb_label 0; trn_ready, busy and done 0; vote_label 0.
- States:
  - IDLE: trn_ready=0. test_load captures test_point, empties the list, and goes to RUN.
  - RUN: trn_ready=1. A beat is accepted when trn_valid&trn_ready. An accepted beat with trn_last goes to DRAIN.
  - DRAIN: trn_ready=0. Wait until both pipeline stages are empty (2 cycles), then go to VOTE if enabled, else DONE.
  - DONE: done=1; outputs frozen. test_load restarts as in IDLE. trn_valid is ignored.
  - clear in any state: IDLE next cycle, list emptied, pipeline flushed. clear has priority over test_load and over an accepted beat.
  - test_load in RUN, DRAIN or VOTE: ignored.
- Arithmetic:
  - diff = sign-extended (trn - test), DATA_W+1 bits; sq = diff*diff, 2*DATA_W+2 bits unsigned.
  - Stage 1 registers all sq values. Stage 2 registers their sum (DIST_W bits, cannot overflow).
- Insertion (stage 3):
  - p = number of valid slots with dist <= d. Ties keep the earlier arrival nearer (stable).
  - If p < K: slots p..K-2 shift to p+1..K-1, the new entry is written at p, and count increments up to saturation at K.
  - If p == K (list full, candidate not nearer than any slot): candidate discarded.
- Latency: a beat accepted in cycle t is visible on nb_* in cycle t+3. Back-to-back beats are accepted every cycle with no bubble.
- Invalid slots always read dist all-ones, label 0.
- trn_last with zero other beats is legal: count 1.

Optional Feature:
- Macro KNN_VOTE_EN.
- Defined:
  - VOTE state lasts exactly K cycles. Cycle i evaluates slot i (skipped if i >= count): votes_i = number of valid slots whose label equals label_i.
  - Running best is replaced only on strictly greater votes, so ties resolve to the nearest slot.
  - vote_label is registered and updated on entry to DONE; done rises K cycles later than without the feature.
  - count 0 is not reachable from a completed run.
- Undefined: no VOTE state; DRAIN goes straight to DONE; vote_label is tied to 0.

Test Plan (DATA_W=16, N_DIM=2, K=3):
- Basic sort: test (0,0); beats (3,4)L1, (1,1)L2, (-2,0)L3+last → nb_dist {2,4,25}, nb_label {2,3,1}, count 3, done 1; first beat visible 3 cycles after acceptance.
- Eviction and head insert: continue from the basic-sort list with (10,0)L7 then (0,1)L9+last → L7 discarded; list {1,2,4}, labels {9,2,3}.
- Ties and partial fill: beats (2,0)L5, (0,-2)L6+last → dist {4,4,all-ones}, labels {5,6,0}, count 2.
- Extremes: test (-32768,-32768), beat (32767,32767)+last → dist 8589672450, no wrap.
- Control: rst low mid-RUN → all outputs at reset values in the same cycle. clear with trn_valid high → IDLE next cycle, beat not inserted, count 0. test_load during RUN → ignored.
- KNN_VOTE_EN: labels {2,2,1} → vote_label 2. Labels {4,7,9} → vote_label 4 (nearest). done exactly K=3 cycles after DRAIN ends.
